elevator_car_model: RTL and testbench
=====================================

Name: elevator_car_model

Overview:
Behavioural plant model of the elevator car and door, the responder to the elevator controller's actuator commands. It consumes engine_up/engine_down/open_door/close_door and returns the car's floor position, door state and motion state after realistic travel and door delays. It closes the loop in controller benches and flags any illegal command sequence through a sticky fault.

Parameters:
FLOORS, 6, number of floors; width of level_sensor; must equal the controller's BUTTONS_WIDTH.
TRAVEL_CYCLES, 8, clock cycles to travel one floor (>=2).
DOOR_CYCLES, 4, clock cycles for a full door open or close stroke (>=2).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-low reset.
engine_up  input  1  controller command: drive car up.
engine_down  input  1  controller command: drive car down.
open_door  input  1  controller command: open door.
close_door  input  1  controller command: close door.
level_sensor  output  FLOORS  one-hot current or last-passed floor; bit 0 = ground floor.
at_floor  output  1  car stationary and aligned at a floor.
moving_up  output  1  car travelling up.
moving_down  output  1  car travelling down.
door_is_open  output  1  door fully open.
door_is_closed  output  1  door fully closed.
fault  output  1  sticky illegal-command flag.

Behaviour:
- All outputs registered. Commands sampled on the rising clk edge; effect visible after that edge.
- Reset (reset=0 at edge): state IDLE, pos=0, level_sensor=1, at_floor=1, door_is_closed=1, door_is_open=0, moving_up=0, moving_down=0, fault=0, counters=0. Reset mid-operation aborts any motion or door stroke immediately.
- States: IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING, FAULT.
- Fault conditions, checked first in every non-FAULT state: engine_up&engine_down; open_door&close_door; any engine command while door_is_closed=0; any door command while moving; engine_down in MOVING_UP or engine_up in MOVING_DOWN. On a fault the next state is FAULT.
- FAULT: fault=1, moving_up=moving_down=0; pos, level_sensor and door outputs frozen. Exited only by reset.
- IDLE:
  - engine_up with pos<FLOORS-1 -> MOVING_UP, travel counter=0, at_floor=0, moving_up=1.
  - engine_down with pos>0 -> MOVING_DOWN, same timing with moving_down=1.
  - Limit switch: engine_up at the top floor or engine_down at floor 0 is ignored, with no fault.
  - open_door alone -> DOOR_OPENING, door_is_closed=0, door counter=0.
  - close_door alone -> no-op.
- MOVING_UP/MOVING_DOWN:
  - The travel counter increments every cycle, regardless of whether the engine command is still held. Releasing the command mid-travel makes the car coast to the next floor.
  - When the counter reaches TRAVEL_CYCLES-1, on that edge pos changes by ±1, level_sensor is shifted and the counter clears.
  - If the engine command is still asserted and the car is not at the limit floor: stay in the state. at_floor pulses 1 for that cycle only; level_sensor is updated.
  - Otherwise -> IDLE: at_floor=1, moving flag cleared.
  - Result: one floor costs exactly TRAVEL_CYCLES edges.
- DOOR_OPENING: the door counter increments; at DOOR_CYCLES-1 -> DOOR_OPEN, door_is_open=1.
- DOOR_OPEN: close_door -> DOOR_CLOSING, door_is_open=0, counter=0. open_door -> no-op.
- DOOR_CLOSING:
  - The counter increments; at DOOR_CYCLES-1 -> IDLE, door_is_closed=1.
  - open_door while closing reverses the stroke: -> DOOR_OPENING, with the counter preset to DOOR_CYCLES-1-count, so reopening takes as many cycles as were already spent closing.
- door_is_open and door_is_closed are never 1 together; both are 0 during a stroke.
- moving_up, moving_down and at_floor are mutually exclusive, except for the at_floor pulse on a pass-through floor.
- level_sensor is always one-hot.

Test Plan:
1. Single floor up: reset released, engine_up=1 for one cycle at edge k -> moving_up=1, at_floor=0 after edge k; level_sensor=000010 and at_floor=1 after edge k+8; moving_up=0 after edge k+8.
2. Multi-floor and limit: engine_up held continuously from floor 0 -> at_floor pulses after edges k+8, k+16, k+24, k+32. Car stops at level_sensor=100000 after edge k+40. engine_up still held at the top gives no movement and fault=0.
3. Door cycle: open_door at edge k -> door_is_closed=0 after k, door_is_open=1 after k+4. close_door at edge m -> door_is_closed=1 after m+4.
4. Door reversal: open, then close_door at edge m, then open_door at edge m+2 -> door_is_open=1 after edge m+4, door never reaches closed.
5. Faults (one run each, reset between): engine_up&engine_down in IDLE; engine_up while door open; open_door while moving_up -> fault=1 next cycle. Outputs then frozen and stay so with further commands; reset=0 for one edge restores the reset values.
6. Reset mid-travel: engine_down from floor 2, reset=0 after 3 cycles of travel -> level_sensor=000001, at_floor=1, moving_down=0 after that edge.

Source files
------------

// File: rtl/elevator_car_model.sv
// Elevator car and door plant model: turns engine/door commands into
// floor position, door state and motion state after travel/door delays.
// Ports:
//   clk, reset (sync, active-low)
//   engine_up, engine_down, open_door, close_door : actuator commands
//   level_sensor : one-hot current/last-passed floor (bit 0 = ground)
//   at_floor, moving_up, moving_down : motion state
//   door_is_open, door_is_closed : door end-of-stroke state
//   fault : sticky illegal-command flag, cleared only by reset
module elevator_car_model #(
    parameter int FLOORS        = 6,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              engine_up,
    input  logic              engine_down,
    input  logic              open_door,
    input  logic              close_door,
    output logic [FLOORS-1:0] level_sensor,
    output logic              at_floor,
    output logic              moving_up,
    output logic              moving_down,
    output logic              door_is_open,
    output logic              door_is_closed,
    output logic              fault
);

    localparam int PW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
    localparam int TW = $clog2(TRAVEL_CYCLES);
    localparam int DW = $clog2(DOOR_CYCLES);

    localparam logic [PW-1:0] TOP_POS = PW'(FLOORS - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST  = DW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVING_UP,
        MOVING_DOWN,
        DOOR_OPENING,
        DOOR_OPEN,
        DOOR_CLOSING,
        FAULT
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     pos, pos_nxt;
    logic [TW-1:0]     tcnt, tcnt_nxt;
    logic [DW-1:0]     dcnt, dcnt_nxt;
    logic [FLOORS-1:0] level_nxt;
    logic              at_floor_nxt;
    logic              up_nxt;
    logic              down_nxt;
    logic              open_nxt;
    logic              closed_nxt;
    logic              fault_nxt;

    logic moving;
    logic illegal;

    assign moving = (state == MOVING_UP) || (state == MOVING_DOWN);

    assign illegal = (engine_up && engine_down)
                  || (open_door && close_door)
                  || ((engine_up || engine_down) && !door_is_closed)
                  || ((open_door || close_door) && moving)
                  || ((state == MOVING_UP) && engine_down)
                  || ((state == MOVING_DOWN) && engine_up);

    always_comb begin
        state_nxt    = state;
        pos_nxt      = pos;
        tcnt_nxt     = tcnt;
        dcnt_nxt     = dcnt;
        level_nxt    = level_sensor;
        at_floor_nxt = at_floor;
        up_nxt       = moving_up;
        down_nxt     = moving_down;
        open_nxt     = door_is_open;
        closed_nxt   = door_is_closed;
        fault_nxt    = fault;

        if ((state != FAULT) && illegal) begin
            // Position, level and door outputs freeze where they are.
            state_nxt = FAULT;
            fault_nxt = 1'b1;
            up_nxt    = 1'b0;
            down_nxt  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (engine_up || engine_down) begin
                        // Commands past a limit floor are simply ignored.
                        if (engine_up && (pos != TOP_POS)) begin
                            state_nxt    = MOVING_UP;
                            tcnt_nxt     = '0;
                            at_floor_nxt = 1'b0;
                            up_nxt       = 1'b1;
                        end else if (engine_down && (pos != '0)) begin
                            state_nxt    = MOVING_DOWN;
                            tcnt_nxt     = '0;
                            at_floor_nxt = 1'b0;
                            down_nxt     = 1'b1;
                        end
                    end else if (open_door) begin
                        state_nxt  = DOOR_OPENING;
                        closed_nxt = 1'b0;
                        dcnt_nxt   = '0;
                    end
                end
                MOVING_UP: begin
                    if (tcnt == T_LAST) begin
                        pos_nxt      = pos + 1'b1;
                        level_nxt    = level_sensor << 1;
                        tcnt_nxt     = '0;
                        at_floor_nxt = 1'b1;
                        if (!(engine_up && (pos_nxt != TOP_POS))) begin
                            state_nxt = IDLE;
                            up_nxt    = 1'b0;
                        end
                    end else begin
                        // Travel continues whether or not the command is held.
                        tcnt_nxt     = tcnt + 1'b1;
                        at_floor_nxt = 1'b0;
                    end
                end
                MOVING_DOWN: begin
                    if (tcnt == T_LAST) begin
                        pos_nxt      = pos - 1'b1;
                        level_nxt    = level_sensor >> 1;
                        tcnt_nxt     = '0;
                        at_floor_nxt = 1'b1;
                        if (!(engine_down && (pos_nxt != '0))) begin
                            state_nxt = IDLE;
                            down_nxt  = 1'b0;
                        end
                    end else begin
                        tcnt_nxt     = tcnt + 1'b1;
                        at_floor_nxt = 1'b0;
                    end
                end
                DOOR_OPENING: begin
                    if (dcnt == D_LAST) begin
                        state_nxt = DOOR_OPEN;
                        open_nxt  = 1'b1;
                        dcnt_nxt  = '0;
                    end else begin
                        dcnt_nxt = dcnt + 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    if (close_door) begin
                        state_nxt = DOOR_CLOSING;
                        open_nxt  = 1'b0;
                        dcnt_nxt  = '0;
                    end
                end
                DOOR_CLOSING: begin
                    if (open_door) begin
                        // Reopen from the current door position: the
                        // remaining stroke equals the time spent closing.
                        state_nxt = DOOR_OPENING;
                        dcnt_nxt  = D_LAST - dcnt;
                    end else if (dcnt == D_LAST) begin
                        state_nxt  = IDLE;
                        closed_nxt = 1'b1;
                        dcnt_nxt   = '0;
                    end else begin
                        dcnt_nxt = dcnt + 1'b1;
                    end
                end
                FAULT: begin
                    up_nxt   = 1'b0;
                    down_nxt = 1'b0;
                end
                default: begin
                    state_nxt = FAULT;
                    fault_nxt = 1'b1;
                    up_nxt    = 1'b0;
                    down_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            pos            <= '0;
            tcnt           <= '0;
            dcnt           <= '0;
            level_sensor   <= FLOORS'(1);
            at_floor       <= 1'b1;
            moving_up      <= 1'b0;
            moving_down    <= 1'b0;
            door_is_open   <= 1'b0;
            door_is_closed <= 1'b1;
            fault          <= 1'b0;
        end else begin
            state          <= state_nxt;
            pos            <= pos_nxt;
            tcnt           <= tcnt_nxt;
            dcnt           <= dcnt_nxt;
            level_sensor   <= level_nxt;
            at_floor       <= at_floor_nxt;
            moving_up      <= up_nxt;
            moving_down    <= down_nxt;
            door_is_open   <= open_nxt;
            door_is_closed <= closed_nxt;
            fault          <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_car_model.sv
// Scoreboard bench for elevator_car_model.
// Queued vectors plus inline checks on the falling edge.
module tb_elevator_car_model;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         engine_up = 1'b0;
  logic         engine_down = 1'b0;
  logic         open_door = 1'b0;
  logic         close_door = 1'b0;
  logic [N-1:0] level_sensor;
  logic         at_floor;
  logic         moving_up;
  logic         moving_down;
  logic         door_is_open;
  logic         door_is_closed;
  logic         fault;

  elevator_car_model #(
    .FLOORS(N),
    .TRAVEL_CYCLES(8),
    .DOOR_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .engine_up(engine_up),
    .engine_down(engine_down),
    .open_door(open_door),
    .close_door(close_door),
    .level_sensor(level_sensor),
    .at_floor(at_floor),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_is_open(door_is_open),
    .door_is_closed(door_is_closed),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [11:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic logic [11:0] mk(
    input logic [5:0] ls,
    input logic af, mu, md,
    input logic op, cl, f
  );
    return {ls, af, mu, md, op, cl, f};
  endfunction

  localparam logic [11:0] RST = 12'b000001_100_010;

  logic [11:0] obs;
  assign obs = {level_sensor, at_floor,
                moving_up, moving_down,
                door_is_open, door_is_closed,
                fault};

  exp_t head;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      head = sb.pop_front();
      applied++;
      if (obs !== head.v) begin
        miscompares++;
        $display("FAIL %s @cycle %0d: got %b required %b",
                 head.name, cyc, obs, head.v);
      end
    end
  end

  task automatic expect_at(
    input int c,
    input logic [11:0] v,
    input string name
  );
    exp_t e;
    e.cyc  = c;
    e.v    = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic go(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    engine_up   = 1'b0;
    engine_down = 1'b0;
    open_door   = 1'b0;
    close_door  = 1'b0;
    expect_at(cyc + 1, RST, "reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int m;
    @(negedge clk);
    do_reset();

    k = cyc + 1;
    engine_up = 1'b1;
    expect_at(k, mk(6'b000001, 0, 1, 0, 0, 1, 0), "up1_start");
    @(negedge clk);
    engine_up = 1'b0;
    expect_at(k + 7, mk(6'b000001, 0, 1, 0, 0, 1, 0), "up1_travel");
    expect_at(k + 8, mk(6'b000010, 1, 0, 0, 0, 1, 0), "up1_arrive");
    go(k + 10);
    applied++;
    if (obs !== mk(6'b000010, 1, 0, 0, 0, 1, 0)) begin
      miscompares++;
      $display("FAIL up1_rest: got %b", obs);
    end

    do_reset();
    k = cyc + 1;
    engine_up = 1'b1;
    expect_at(k, mk(6'b000001, 0, 1, 0, 0, 1, 0), "multi_start");
    for (int i = 1; i <= 4; i++) begin
      expect_at(k + 8 * i, mk(6'(1 << i), 1, 1, 0, 0, 1, 0),
                "pass_pulse");
      expect_at(k + 8 * i + 1, mk(6'(1 << i), 0, 1, 0, 0, 1, 0),
                "pass_clear");
    end
    expect_at(k + 40, mk(6'b100000, 1, 0, 0, 0, 1, 0), "top_stop");
    expect_at(k + 45, mk(6'b100000, 1, 0, 0, 0, 1, 0), "top_limit");
    go(k + 46);
    applied++;
    if (obs !== mk(6'b100000, 1, 0, 0, 0, 1, 0)) begin
      miscompares++;
      $display("FAIL top_held: got %b", obs);
    end
    engine_up = 1'b0;

    k = cyc + 1;
    open_door = 1'b1;
    expect_at(k, mk(6'b100000, 1, 0, 0, 0, 0, 0), "open_start");
    @(negedge clk);
    open_door = 1'b0;
    expect_at(k + 3, mk(6'b100000, 1, 0, 0, 0, 0, 0), "open_mid");
    expect_at(k + 4, mk(6'b100000, 1, 0, 0, 1, 0, 0), "open_done");
    go(k + 6);
    m = cyc + 1;
    close_door = 1'b1;
    expect_at(m, mk(6'b100000, 1, 0, 0, 0, 0, 0), "close_start");
    @(negedge clk);
    close_door = 1'b0;
    expect_at(m + 3, mk(6'b100000, 1, 0, 0, 0, 0, 0), "close_mid");
    expect_at(m + 4, mk(6'b100000, 1, 0, 0, 0, 1, 0), "close_done");
    go(m + 6);
    applied++;
    if (obs !== mk(6'b100000, 1, 0, 0, 0, 1, 0)) begin
      miscompares++;
      $display("FAIL close_rest: got %b", obs);
    end

    k = cyc + 1;
    open_door = 1'b1;
    @(negedge clk);
    open_door = 1'b0;
    go(k + 5);
    m = cyc + 1;
    close_door = 1'b1;
    expect_at(m, mk(6'b100000, 1, 0, 0, 0, 0, 0), "rev_close");
    @(negedge clk);
    close_door = 1'b0;
    @(negedge clk);
    open_door = 1'b1;
    expect_at(m + 2, mk(6'b100000, 1, 0, 0, 0, 0, 0), "rev_turn");
    @(negedge clk);
    open_door = 1'b0;
    expect_at(m + 3, mk(6'b100000, 1, 0, 0, 0, 0, 0), "rev_mid");
    expect_at(m + 4, mk(6'b100000, 1, 0, 0, 1, 0, 0), "rev_open");
    go(m + 5);
    close_door = 1'b1;
    @(negedge clk);
    close_door = 1'b0;
    expect_at(m + 9, mk(6'b100000, 1, 0, 0, 0, 1, 0), "rev_closed");
    go(m + 10);

    k = cyc + 1;
    engine_down = 1'b1;
    expect_at(k, mk(6'b100000, 0, 0, 1, 0, 1, 0), "down_start");
    @(negedge clk);
    engine_down = 1'b0;
    expect_at(k + 2, mk(6'b100000, 0, 0, 1, 0, 1, 0), "down_travel");
    go(k + 3);
    do_reset();
    expect_at(k + 5, RST, "post_reset");
    go(k + 6);

    k = cyc + 1;
    engine_down = 1'b1;
    expect_at(k, RST, "down_limit");
    @(negedge clk);
    engine_down = 1'b0;
    go(k + 2);
    applied++;
    if (obs !== RST) begin
      miscompares++;
      $display("FAIL down_limit_rest: got %b", obs);
    end

    k = cyc + 1;
    engine_up   = 1'b1;
    engine_down = 1'b1;
    expect_at(k, mk(6'b000001, 1, 0, 0, 0, 1, 1), "flt_both");
    @(negedge clk);
    engine_up   = 1'b0;
    engine_down = 1'b0;
    open_door   = 1'b1;
    @(negedge clk);
    open_door = 1'b0;
    expect_at(k + 3, mk(6'b000001, 1, 0, 0, 0, 1, 1), "flt_both_hold");
    go(k + 4);
    applied++;
    if (obs !== mk(6'b000001, 1, 0, 0, 0, 1, 1)) begin
      miscompares++;
      $display("FAIL flt_both_end: got %b", obs);
    end
    do_reset();

    k = cyc + 1;
    open_door = 1'b1;
    @(negedge clk);
    open_door = 1'b0;
    go(k + 5);
    m = cyc + 1;
    engine_up = 1'b1;
    expect_at(m, mk(6'b000001, 1, 0, 0, 1, 0, 1), "flt_door");
    @(negedge clk);
    engine_up  = 1'b0;
    close_door = 1'b1;
    @(negedge clk);
    close_door = 1'b0;
    expect_at(m + 3, mk(6'b000001, 1, 0, 0, 1, 0, 1), "flt_door_hold");
    go(m + 4);
    applied++;
    if (obs !== mk(6'b000001, 1, 0, 0, 1, 0, 1)) begin
      miscompares++;
      $display("FAIL flt_door_end: got %b", obs);
    end
    do_reset();

    k = cyc + 1;
    engine_up = 1'b1;
    expect_at(k, mk(6'b000001, 0, 1, 0, 0, 1, 0), "flt_mv_start");
    @(negedge clk);
    engine_up = 1'b0;
    @(negedge clk);
    open_door = 1'b1;
    expect_at(k + 2, mk(6'b000001, 0, 0, 0, 0, 1, 1), "flt_mv");
    @(negedge clk);
    open_door   = 1'b0;
    engine_down = 1'b1;
    @(negedge clk);
    engine_down = 1'b0;
    expect_at(k + 5, mk(6'b000001, 0, 0, 0, 0, 1, 1), "flt_mv_hold");
    go(k + 6);
    do_reset();

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      head = sb.pop_front();
      applied++;
      miscompares++;
      $display("FAIL %s: never checked, required %b at cycle %0d",
               head.name, head.v, head.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
